// File: rtl/regfile_mp_scoreboard.sv
// Integer register file for the decode stage.
//   - 2 combinational read ports, 2 write ports:
//     wb0 is the in-order pipeline writeback, wb1 the long-latency MUL/DIV writeback.
//   - Optional write-to-read bypass (BYPASS).
//   - Per-register pending scoreboard for long-latency results.
//   - After reset the array is zeroed by a sequential sweep of NREGS cycles,
//     so the array itself never needs a wide parallel reset.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   init_busy            high during reset and during the zero-init sweep
//   rs1_addr/rs2_addr    read addresses
//   rs1_data/rs2_data    read data (combinational)
//   rs1_pending/rs2_pending
//                        the addressed register is waiting for a wb1 result
//   wb0_en/addr/data     pipeline writeback
//   wb1_en/addr/data     long-latency writeback; also clears the pending bit
//   issue_en/issue_rd    long-latency op issued; sets the pending bit
//   collision_err        sticky: wb0 and wb1 wrote the same register in one cycle
module regfile_mp_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_pending,
  output logic              rs2_pending,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [XLEN-1:0]   wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [XLEN-1:0]   wb1_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              collision_err
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NREGS - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic [NREGS-1:0]    pending_q, pending_d;
  logic                collision_q, collision_d;
  logic [XLEN-1:0]     regs_q [NREGS];

  logic run;
  logic wb0_we, wb1_we;
  logic collide;
  logic sweep_we;

  // Normal operation only once the sweep is done and reset is not being applied.
  assign run = (state_q == StRun) && !rst;

  // Effective writes: register 0 is hardwired when ZERO_REG is set.
  assign wb0_we  = run && wb0_en && !(ZERO_REG && (wb0_addr == '0));
  assign wb1_we  = run && wb1_en && !(ZERO_REG && (wb1_addr == '0));
  assign collide = wb0_we && wb1_we && (wb0_addr == wb1_addr);

  assign sweep_we = (state_q == StInit) && !rst;

  // ---------------------------------------------------------------------------
  // FSM and control state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    pending_d   = pending_q;
    collision_d = collision_q;

    unique case (state_q)
      StInit: begin
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        // Terminal compare keeps the counter at ADDR_W bits without wrapping past NREGS.
        if (sweep_cnt_q == LastReg) begin
          sweep_cnt_d = '0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (collide) begin
          collision_d = 1'b1;
        end
        if (wb1_en) begin
          pending_d[wb1_addr] = 1'b0;
        end
        // Applied after the clear so a new issue re-owns the register.
        if (issue_en && !(ZERO_REG && (issue_rd == '0))) begin
          pending_d[issue_rd] = 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_cnt_q <= '0;
      pending_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      pending_q   <= pending_d;
      collision_q <= collision_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register array (no reset; zeroed by the sweep)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      regs_q[sweep_cnt_q] <= '0;
    end else begin
      // wb1 is suppressed on a collision so wb0 owns the register.
      if (wb1_we && !collide) begin
        regs_q[wb1_addr] <= wb1_data;
      end
      if (wb0_we) begin
        regs_q[wb0_addr] <= wb0_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rs1_data = '0;
    if (!run) begin
      rs1_data = '0;
    end else if (ZERO_REG && (rs1_addr == '0)) begin
      rs1_data = '0;
    end else if (BYPASS && wb0_en && (wb0_addr == rs1_addr)) begin
      rs1_data = wb0_data;
    end else if (BYPASS && wb1_en && (wb1_addr == rs1_addr)) begin
      rs1_data = wb1_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (!run) begin
      rs2_data = '0;
    end else if (ZERO_REG && (rs2_addr == '0)) begin
      rs2_data = '0;
    end else if (BYPASS && wb0_en && (wb0_addr == rs2_addr)) begin
      rs2_data = wb0_data;
    end else if (BYPASS && wb1_en && (wb1_addr == rs2_addr)) begin
      rs2_data = wb1_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // A wb1 result arriving this cycle resolves the hazard immediately when bypassed.
  assign rs1_pending = run && pending_q[rs1_addr] &&
                       !(BYPASS && wb1_en && (wb1_addr == rs1_addr));
  assign rs2_pending = run && pending_q[rs2_addr] &&
                       !(BYPASS && wb1_en && (wb1_addr == rs2_addr));

  assign init_busy     = rst || (state_q == StInit);
  assign collision_err = collision_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard with default parameters
// (XLEN=32, ADDR_W=5, ZERO_REG=1, BYPASS=1).
module tb_regfile_mp_scoreboard;

  logic        clk;
  logic        rst;
  logic        init_busy;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_pending, rs2_pending;
  logic        wb0_en, wb1_en, issue_en;
  logic [4:0]  wb0_addr, wb1_addr, issue_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        collision_err;

  int n_checks = 0;
  int n_errs   = 0;

  regfile_mp_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .init_busy     (init_busy),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rs1_pending   (rs1_pending),
    .rs2_pending   (rs2_pending),
    .wb0_en        (wb0_en),
    .wb0_addr      (wb0_addr),
    .wb0_data      (wb0_data),
    .wb1_en        (wb1_en),
    .wb1_addr      (wb1_addr),
    .wb1_data      (wb1_data),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .collision_err (collision_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb0_en   = 1'b0; wb0_addr = '0; wb0_data = '0;
    wb1_en   = 1'b0; wb1_addr = '0; wb1_data = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  // Count cycles until init_busy drops, with a bound.
  task automatic wait_init(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      check({tag, "_data_in_init"}, rs1_data, 32'h0);
      tick();
      n++;
    end
    check({tag, "_init_cycles"}, n, exp_cycles);
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr = '0;
    rs2_addr = '0;
    idle_inputs();

    // T1: one reset cycle, then a 32-cycle sweep; all registers read 0.
    tick();
    check("t1_busy_in_rst", init_busy, 1'b1);
    check("t1_coll_rst", collision_err, 1'b0);
    rst = 1'b0;
    #1;
    check("t1_pend_init", rs1_pending, 1'b0);
    wait_init("t1", 32);
    check("t1_busy_run", init_busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("t1_rs1_x%0d", i), rs1_data, 32'h0);
      check($sformatf("t1_rs2_x%0d", 31 - i), rs2_data, 32'h0);
    end

    // T2: same-cycle bypass of wb0, then value held in the array.
    wb0_en = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    rs1_addr = 5'd5;
    #1;
    check("t2_bypass", rs1_data, 32'hDEADBEEF);
    tick();
    idle_inputs();
    #1;
    check("t2_held", rs1_data, 32'hDEADBEEF);

    // T3: x0 ignores writes and is never pending.
    wb0_en = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd0;
    rs2_addr = 5'd0;
    #1;
    check("t3_x0_bypass", rs2_data, 32'h0);
    tick();
    idle_inputs();
    #1;
    check("t3_x0_data", rs2_data, 32'h0);
    check("t3_x0_pend", rs2_pending, 1'b0);

    // T4: long-latency op on x7.
    issue_en = 1'b1; issue_rd = 5'd7;
    rs1_addr = 5'd7;
    #1;
    check("t4_pend_before", rs1_pending, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_pend_c%0d", i), rs1_pending, 1'b1);
      tick();
    end
    wb1_en = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h55;
    #1;
    check("t4_pend_wb1", rs1_pending, 1'b0);
    check("t4_data_wb1", rs1_data, 32'h55);
    tick();
    idle_inputs();
    #1;
    check("t4_pend_after", rs1_pending, 1'b0);
    check("t4_data_after", rs1_data, 32'h55);

    // Set and clear of x8 in the same cycle: set wins; wb0 leaves pending alone.
    issue_en = 1'b1; issue_rd = 5'd8;
    tick();
    issue_en = 1'b1; issue_rd = 5'd8;
    wb1_en = 1'b1; wb1_addr = 5'd8; wb1_data = 32'h77;
    rs2_addr = 5'd8;
    #1;
    check("t4b_pend_masked", rs2_pending, 1'b0);
    tick();
    idle_inputs();
    wb0_en = 1'b1; wb0_addr = 5'd8; wb0_data = 32'h99;
    #1;
    check("t4b_pend_setwins", rs2_pending, 1'b1);
    tick();
    idle_inputs();
    #1;
    check("t4b_pend_wb0", rs2_pending, 1'b1);
    check("t4b_data_wb0", rs2_data, 32'h99);

    // T5: collision on x9; wb0 wins, sticky error.
    check("t5_coll_before", collision_err, 1'b0);
    wb0_en = 1'b1; wb0_addr = 5'd9; wb0_data = 32'hA;
    wb1_en = 1'b1; wb1_addr = 5'd9; wb1_data = 32'hB;
    rs1_addr = 5'd9;
    #1;
    check("t5_bypass_wb0", rs1_data, 32'hA);
    tick();
    idle_inputs();
    #1;
    check("t5_x9", rs1_data, 32'hA);
    check("t5_coll", collision_err, 1'b1);
    tick();
    check("t5_coll_sticky", collision_err, 1'b1);

    // Leave x12 pending so the reset below must clear it.
    issue_en = 1'b1; issue_rd = 5'd12;
    tick();
    idle_inputs();

    // T6: reset, abort the sweep at cycle 10, restart; inputs ignored in INIT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_coll_cleared", collision_err, 1'b0);
    wb0_en = 1'b1; wb0_addr = 5'd2; wb0_data = 32'hCAFE;
    issue_en = 1'b1; issue_rd = 5'd2;
    for (int i = 0; i < 10; i++) tick();
    check("t6_busy_mid", init_busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    wait_init("t6", 32);
    idle_inputs();
    rs1_addr = 5'd12;
    rs2_addr = 5'd5;
    #1;
    check("t6_pend_x12", rs1_pending, 1'b0);
    check("t6_x5_zero", rs2_data, 32'h0);
    rs1_addr = 5'd2;
    rs2_addr = 5'd8;
    #1;
    check("t6_x2_ignored", rs1_data, 32'h0);
    check("t6_pend_x2", rs1_pending, 1'b0);
    check("t6_pend_x8", rs2_pending, 1'b0);
    check("t6_coll", collision_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
